// File: rtl/crop_filter.sv
// Raster-order crop: forwards only the pixels inside a fixed window, 1-cycle latency, valid/ready on both sides.
// Optional build macro CROP_FILTER_SKID_EN adds a one-entry skid buffer so in_ready comes straight from a flop.
module crop_filter #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 40,
    parameter int IN_COLS         = 40,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int Y_1             = 10,
    parameter int X_1             = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);
    localparam logic [ROW_W:0]   ROW_Y1   = (ROW_W + 1)'(Y_1);
    localparam logic [COL_W:0]   COL_X1   = (COL_W + 1)'(X_1);
    localparam logic [ROW_W:0]   ROW_SPAN = (ROW_W + 1)'(OUT_ROWS);
    localparam logic [COL_W:0]   COL_SPAN = (COL_W + 1)'(OUT_COLS);

    if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS) ||
        (OUT_ROWS < 1) || (OUT_COLS < 1) || (Y_1 < 0) || (X_1 < 0)) begin : g_param_err
        $error("crop_filter: crop window does not fit inside the input frame");
    end

    logic [ROW_W-1:0]           row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic                       out_valid_q, out_valid_d;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out_q, pixel_out_d;

    logic                       in_ready_s;
    logic                       in_xfer_s;
    logic                       out_xfer_s;
    logic                       in_win_s;
    logic                       fwd_s;
    logic [ROW_W:0]             row_off_s;
    logic [COL_W:0]             col_off_s;

    // Offsets below the window origin wrap to a large value, so one unsigned compare covers both bounds.
    always_comb begin
        row_off_s  = {1'b0, row_q} - ROW_Y1;
        col_off_s  = {1'b0, col_q} - COL_X1;
        in_win_s   = (row_off_s < ROW_SPAN) && (col_off_s < COL_SPAN);
        in_xfer_s  = in_valid && in_ready_s;
        out_xfer_s = out_valid_q && out_ready;
        fwd_s      = in_xfer_s && in_win_s;
    end

    // Raster position of the next pixel to be accepted.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (in_xfer_s) begin
            if (col_q == COL_LAST) begin
                col_d = {COL_W{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

`ifdef CROP_FILTER_SKID_EN
    logic                       skid_empty_q, skid_empty_d;
    logic [PIXEL_BIT_WIDTH-1:0] skid_data_q, skid_data_d;

    assign in_ready_s = skid_empty_q;

    // A pixel forwarded while the output is stalled parks in the skid entry and is promoted once the output frees up.
    always_comb begin
        out_valid_d  = out_valid_q;
        pixel_out_d  = pixel_out_q;
        skid_empty_d = skid_empty_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (!skid_empty_q) begin
                out_valid_d  = 1'b1;
                pixel_out_d  = skid_data_q;
                skid_empty_d = 1'b1;
            end else if (fwd_s) begin
                out_valid_d  = 1'b1;
                pixel_out_d  = pixel_in;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else begin
            if (fwd_s) begin
                skid_data_d  = pixel_in;
                skid_empty_d = 1'b0;
            end else begin
                skid_data_d  = skid_data_q;
                skid_empty_d = skid_empty_q;
            end
        end
    end

    // Skid buffer storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_empty_q <= 1'b1;
            skid_data_q  <= {PIXEL_BIT_WIDTH{1'b0}};
        end else begin
            skid_empty_q <= skid_empty_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready_s = !out_valid_q || out_ready;

    // Load on a forwarded pixel (even while the old one leaves), clear when the held pixel leaves with nothing behind it.
    always_comb begin
        out_valid_d = out_valid_q;
        pixel_out_d = pixel_out_q;
        if (fwd_s) begin
            out_valid_d = 1'b1;
            pixel_out_d = pixel_in;
        end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end
`endif

    // Position counters and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= {ROW_W{1'b0}};
            col_q       <= {COL_W{1'b0}};
            out_valid_q <= 1'b0;
            pixel_out_q <= {PIXEL_BIT_WIDTH{1'b0}};
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign pixel_out = pixel_out_q;

endmodule

// File: tb/tb_crop_filter.sv
// Self-checking bench for crop_filter: stall table, scoreboard over full and random-handshake frames,
// mid-frame reset, plus full-frame and bottom-right-corner parameterisations.
module tb_crop_filter;

    localparam int W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] pixel_in;
    logic         in_valid, in_ready;
    logic [W-1:0] pixel_out;
    logic         out_valid, out_ready;

    logic [W-1:0] c_px;
    logic         c_valid, c_ordy;
    logic         cr_ready, cr_ov, fu_ready, fu_ov;
    logic [W-1:0] cr_po, fu_po;

    crop_filter dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    crop_filter #(.Y_1(30), .X_1(30), .OUT_ROWS(10), .OUT_COLS(10)) u_corner (
        .clk(clk), .reset(reset), .pixel_in(c_px), .in_valid(c_valid), .in_ready(cr_ready),
        .pixel_out(cr_po), .out_valid(cr_ov), .out_ready(c_ordy)
    );

    crop_filter #(.Y_1(0), .X_1(0), .OUT_ROWS(40), .OUT_COLS(40)) u_full (
        .clk(clk), .reset(reset), .pixel_in(c_px), .in_valid(c_valid), .in_ready(fu_ready),
        .pixel_out(fu_po), .out_valid(fu_ov), .out_ready(c_ordy)
    );

    typedef struct {
        bit v;
        bit ordy;
        bit rdy;
        bit ov;
        int po;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    int m_row, m_col, accepted, outs, out_idx;
    int sb[$];
    int got[400];
    bit lat_pending, hold_pending;
    int lat_px, hold_px;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int cur_px();
        return m_row * 40 + m_col;
    endfunction

    function automatic int exp_out(input int idx);
        int k;
        k = idx % 400;
        return (10 + k / 20) * 40 + 10 + k % 20;
    endfunction

    function automatic int corner_exp(input int idx);
        int k;
        k = idx % 100;
        return (30 + k / 10) * 40 + 30 + k % 10;
    endfunction

    function automatic bit in_win(input int r, input int c);
        return (r >= 10) && (r < 30) && (c >= 10) && (c < 30);
    endfunction

    // One clock: drive, book-keep the coming edge at negedge, return 1 time unit after the edge.
    task automatic step(input bit v, input bit ordy, output bit rdy_seen);
        bit in_x, out_x, slot_free;
        int e;
        in_valid  = v;
        pixel_in  = 12'(cur_px());
        out_ready = ordy;
        @(negedge clk);
        if (lat_pending)
            check(out_valid === 1'b1 && pixel_out === 12'(lat_px), "latency", int'(pixel_out), lat_px);
        if (hold_pending)
            check(out_valid === 1'b1 && pixel_out === 12'(hold_px), "hold_stable", int'(pixel_out), hold_px);
        rdy_seen = in_ready;
`ifndef CROP_FILTER_SKID_EN
        check(in_ready === (!out_valid || out_ready), "in_ready_rule", int'(in_ready),
              int'(!out_valid || out_ready));
`endif
        in_x      = in_valid && in_ready;
        out_x     = out_valid && out_ready;
        slot_free = !out_valid || out_ready;
        if (out_x) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_output", int'(pixel_out), -1);
            end else begin
                e = sb.pop_front();
                check(pixel_out === 12'(e), "scoreboard", int'(pixel_out), e);
                check(pixel_out === 12'(exp_out(out_idx)), "output_order", int'(pixel_out), exp_out(out_idx));
            end
            got[outs % 400] = int'(pixel_out);
            outs++;
            out_idx++;
        end
        lat_pending = 1'b0;
        if (in_x) begin
            if (in_win(m_row, m_col)) begin
                sb.push_back(cur_px());
                if (slot_free) begin
                    lat_pending = 1'b1;
                    lat_px      = cur_px();
                end
            end
            accepted++;
            if (m_col == 39) begin
                m_col = 0;
                m_row = (m_row == 39) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        hold_pending = out_valid && !out_ready;
        hold_px      = int'(pixel_out);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, input bit rnd);
        int g;
        bit r, v, o;
        g = 0;
        while (accepted < target && g < 40000) begin
            v = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            o = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            step(v, o, r);
            g++;
        end
        check(accepted == target, "accept_budget", accepted, target);
    endtask

    task automatic drain();
        int g;
        bit r;
        g = 0;
        while (sb.size() > 0 && g < 100) begin
            step(1'b0, 1'b1, r);
            g++;
        end
        check(sb.size() == 0, "drain", sb.size(), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        bit   r;
        int   start, cidx;
        int   cgot[200];

`ifdef CROP_FILTER_SKID_EN
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 410};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 410};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 411};
`else
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 410};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 410};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 411};
`endif
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 412};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 413};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};

        reset = 1'b1; in_valid = 1'b0; pixel_in = '0; out_ready = 1'b0;
        c_valid = 1'b0; c_px = '0; c_ordy = 1'b1;
        m_row = 0; m_col = 0; accepted = 0; outs = 0; out_idx = 0;
        lat_pending = 1'b0; hold_pending = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check(out_valid === 1'b0, "reset_out_valid", int'(out_valid), 0);
        check(pixel_out === 12'd0, "reset_pixel_out", int'(pixel_out), 0);
        reset = 1'b0;
        #1;
        check(in_ready === 1'b1, "in_ready_after_reset", int'(in_ready), 1);

        // Frame 1: reach the window origin, run the stall table, finish at full throughput.
        run_until(410, 1'b0);
        check(out_valid === 1'b0, "no_output_before_window", int'(out_valid), 0);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].ordy, r);
            check(r === tbl[i].rdy, $sformatf("tbl%0d_in_ready", i), int'(r), int'(tbl[i].rdy));
            check(out_valid === tbl[i].ov, $sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
            if (tbl[i].ov)
                check(pixel_out === 12'(tbl[i].po), $sformatf("tbl%0d_pixel_out", i),
                      int'(pixel_out), tbl[i].po);
        end
        run_until(1600, 1'b0);
        drain();
        check(outs == 400, "frame1_count", outs, 400);
        check(got[0] == 410, "frame1_first", got[0], 410);
        check(got[19] == 429, "frame1_20th", got[19], 429);
        check(got[20] == 450, "frame1_21st", got[20], 450);
        check(got[399] == 1189, "frame1_last", got[399], 1189);

        // Three frames with random handshakes on both sides.
        outs = 0;
        run_until(1600 + 3 * 1600, 1'b1);
        drain();
        check(outs == 1200, "random_count", outs, 1200);

        // Mid-frame asynchronous reset with an output held.
        outs = 0;
        start = accepted;
        run_until(start + 415, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check(out_valid === 1'b1, "pre_reset_valid", int'(out_valid), 1);
        #2 reset = 1'b1;
        #1;
        check(out_valid === 1'b0, "async_reset_out_valid", int'(out_valid), 0);
        check(pixel_out === 12'd0, "async_reset_pixel_out", int'(pixel_out), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        sb.delete();
        m_row = 0; m_col = 0; accepted = 0; outs = 0; out_idx = 0;
        lat_pending = 1'b0; hold_pending = 1'b0;
        #1;
        check(in_ready === 1'b1, "in_ready_after_reset2", int'(in_ready), 1);
        run_until(1600, 1'b0);
        drain();
        check(outs == 400, "post_reset_count", outs, 400);
        check(got[0] == 410, "post_reset_first", got[0], 410);

        // Full-frame and bottom-right-corner instances, two frames at full throughput.
        cidx = 0;
        for (int k = 0; k < 3200; k++) begin
            c_valid = 1'b1;
            c_px    = 12'(k % 1600);
            @(negedge clk);
            check(fu_ready === 1'b1, "full_in_ready", int'(fu_ready), 1);
            @(posedge clk);
            #1;
            check(fu_ov === 1'b1 && fu_po === 12'(k % 1600), "full_passthrough", int'(fu_po), k % 1600);
            if (cr_ov === 1'b1) begin
                if (cidx < 200) begin
                    check(cr_po === 12'(corner_exp(cidx)), "corner_order", int'(cr_po), corner_exp(cidx));
                    cgot[cidx] = int'(cr_po);
                end
                cidx++;
            end
        end
        c_valid = 1'b0;
        check(cidx == 200, "corner_count", cidx, 200);
        check(cgot[0] == 1230, "corner_first", cgot[0], 1230);
        check(cgot[99] == 1599, "corner_last", cgot[99], 1599);
        check(cgot[100] == 1230, "corner_next_frame_first", cgot[100], 1230);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
